// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache.
// Returns the instruction combinationally on a hit. On a miss it stalls fetch and
// refills one line from memory, one word per handshake beat.
// Optional feature: define ICACHE_PERF_EN to build the hit/miss performance counters.
// Without it, Hit_count and Miss_count are tied to zero.
module icache_dm #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_fIF,
  output logic [31:0] Instr1_2IF,
  output logic        Stall_2IF,
  input  logic        Flush,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  input  logic [31:0] Mem_data,
  input  logic        Mem_valid,
  output logic [31:0] Hit_count,
  output logic [31:0] Miss_count
);

  localparam int unsigned WB = $clog2(LINE_WORDS);
  localparam int unsigned OB = WB + 2;
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TW = 32 - OB - IB;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e          state_q;
  logic [WB-1:0]   beat_q;
  logic [TW-1:0]   fill_tag_q;
  logic [IB-1:0]   fill_idx_q;
  logic [31:0]     mem_addr_q;
  logic            mem_req_q;
  logic            flush_pend_q;
  logic [NUM_LINES-1:0] valid_q;

  logic [TW-1:0]   tag_q  [NUM_LINES];
  logic [31:0]     data_q [NUM_LINES*LINE_WORDS];

  logic [TW-1:0]   req_tag;
  logic [IB-1:0]   req_idx;
  logic [WB-1:0]   req_off;
  logic            hit;
  logic            miss;
  logic            last_beat;
  logic            unused_addr;

  assign req_tag     = Instr_address_fIF[31:OB+IB];
  assign req_idx     = Instr_address_fIF[OB+IB-1:OB];
  assign req_off     = Instr_address_fIF[OB-1:2];
  assign unused_addr = ^Instr_address_fIF[1:0];
  assign last_beat   = (beat_q == WB'(LINE_WORDS - 1));

  // Lookup is only meaningful in IDLE; stall and data are forced low during reset.
  always_comb begin
    hit        = (state_q == StIdle) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    miss       = (state_q == StIdle) && !hit;
    Stall_2IF  = RESET && (miss || (state_q != StIdle));
    Instr1_2IF = (RESET && hit) ? data_q[{req_idx, req_off}] : 32'h0;
  end

  assign Mem_req  = mem_req_q;
  assign Mem_addr = mem_addr_q;

  // Refill FSM with registered memory-side outputs, valid bits and flush bookkeeping.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Flush) valid_q <= '0;
          if (miss) begin
            state_q    <= StFill;
            fill_tag_q <= req_tag;
            fill_idx_q <= req_idx;
            mem_addr_q <= {Instr_address_fIF[31:OB], OB'(0)};
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
          end
        end
        StFill: begin
          if (Flush) flush_pend_q <= 1'b1;
          if (Mem_valid) begin
            beat_q     <= beat_q + 1'b1;
            mem_addr_q <= mem_addr_q + 32'd4;
            if (last_beat) begin
              // A flush seen during the fill leaves the new line invalid.
              if (!(flush_pend_q || Flush)) valid_q[fill_idx_q] <= 1'b1;
              mem_req_q <= 1'b0;
              state_q   <= StDone;
            end
          end
        end
        StDone: begin
          if (flush_pend_q || Flush) valid_q <= '0;
          flush_pend_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays: written only by accepted refill beats, no reset needed.
  always_ff @(posedge CLK) begin
    if (state_q == StFill && Mem_valid) begin
      data_q[{fill_idx_q, beat_q}] <= Mem_data;
      if (last_beat) tag_q[fill_idx_q] <= fill_tag_q;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Performance counters; only reset clears them, flush does not.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign Hit_count  = hit_cnt_q;
  assign Miss_count = miss_cnt_q;
`else
  assign Hit_count  = 32'h0;
  assign Miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm at default parameters.
module tb_icache_dm;

`ifdef ICACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK;
  logic        RESET;
  logic [31:0] Instr_address_fIF;
  logic [31:0] Instr1_2IF;
  logic        Stall_2IF;
  logic        Flush;
  logic        Mem_req;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_data;
  logic        Mem_valid;
  logic [31:0] Hit_count;
  logic [31:0] Miss_count;

  int checks = 0;
  int errors = 0;

  icache_dm #(
    .LINE_WORDS(4),
    .NUM_LINES (64)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .Instr_address_fIF(Instr_address_fIF),
    .Instr1_2IF       (Instr1_2IF),
    .Stall_2IF        (Stall_2IF),
    .Flush            (Flush),
    .Mem_req          (Mem_req),
    .Mem_addr         (Mem_addr),
    .Mem_data         (Mem_data),
    .Mem_valid        (Mem_valid),
    .Hit_count        (Hit_count),
    .Miss_count       (Miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives FILL beats then the DONE cycle; caller has already done the miss cycle.
  task automatic do_fill(input logic [31:0] base, input logic [31:0] d0, input bit gapped);
    for (int k = 0; k < 4; k++) begin
      if (gapped) begin
        step();
        Mem_valid = 1'b0;
        #1;
        chk("gap_req", {31'h0, Mem_req}, 32'd1);
        chk("gap_addr_hold", Mem_addr, base + 32'(4 * k));
        chk("gap_stall", {31'h0, Stall_2IF}, 32'd1);
      end
      step();
      Mem_valid = 1'b1;
      Mem_data  = d0 + 32'(k);
      #1;
      chk("fill_req", {31'h0, Mem_req}, 32'd1);
      chk("fill_addr", Mem_addr, base + 32'(4 * k));
      chk("fill_stall", {31'h0, Stall_2IF}, 32'd1);
      chk("fill_instr", Instr1_2IF, 32'h0);
    end
    step();
    Mem_valid = 1'b0;
    #1;
    chk("done_req", {31'h0, Mem_req}, 32'd0);
    chk("done_stall", {31'h0, Stall_2IF}, 32'd1);
  endtask

  initial begin
    RESET             = 1'b0;
    Flush             = 1'b0;
    Mem_valid         = 1'b0;
    Mem_data          = 32'h0;
    Instr_address_fIF = 32'h0;
    #12;
    chk("rst_stall", {31'h0, Stall_2IF}, 32'd0);
    chk("rst_instr", Instr1_2IF, 32'h0);
    chk("rst_req", {31'h0, Mem_req}, 32'd0);
    chk("rst_addr", Mem_addr, 32'h0);
    chk("rst_hit_cnt", Hit_count, 32'h0);
    chk("rst_miss_cnt", Miss_count, 32'h0);

    // Cold miss: miss cycle is the one right after reset release.
    RESET             = 1'b1;
    Instr_address_fIF = 32'hBFC0_0000;
    Mem_valid         = 1'b1;
    #1;
    chk("cold_stall0", {31'h0, Stall_2IF}, 32'd1);
    chk("cold_req0", {31'h0, Mem_req}, 32'd0);
    do_fill(32'hBFC0_0000, 32'h1000, 1'b0);
    step();
    #1;
    chk("cold_hit_stall", {31'h0, Stall_2IF}, 32'd0);
    chk("cold_hit_instr", Instr1_2IF, 32'h1000);

    // Sequential hits within the line.
    for (int k = 1; k < 4; k++) begin
      step();
      Instr_address_fIF = 32'hBFC0_0000 + 32'(4 * k);
      #1;
      chk("seq_stall", {31'h0, Stall_2IF}, 32'd0);
      chk("seq_instr", Instr1_2IF, 32'h1000 + 32'(k));
    end

    // Conflict miss on index 0 with a new tag.
    step();
    Instr_address_fIF = 32'hBFC0_0400;
    #1;
    chk("conf_stall0", {31'h0, Stall_2IF}, 32'd1);
    chk("conf_instr0", Instr1_2IF, 32'h0);
    chk("hit_cnt_after_cold", Hit_count, pexp(4));
    chk("miss_cnt_after_cold", Miss_count, pexp(1));
    do_fill(32'hBFC0_0400, 32'h2000, 1'b0);
    step();
    #1;
    chk("conf_hit_instr", Instr1_2IF, 32'h2000);
    chk("conf_hit_stall", {31'h0, Stall_2IF}, 32'd0);
    step();
    Instr_address_fIF = 32'hBFC0_0000;
    #1;
    chk("conf_remiss_stall", {31'h0, Stall_2IF}, 32'd1);
    do_fill(32'hBFC0_0000, 32'h1000, 1'b0);
    chk("miss_cnt_conflict", Miss_count, pexp(3));
    step();
    #1;
    chk("conf_refill_instr", Instr1_2IF, 32'h1000);

    // Gapped memory: Mem_valid 0,1,0,1,... stretches the stall to 10 cycles.
    step();
    Instr_address_fIF = 32'hBFC0_0010;
    #1;
    chk("gap_stall0", {31'h0, Stall_2IF}, 32'd1);
    do_fill(32'hBFC0_0010, 32'h3000, 1'b1);
    step();
    #1;
    chk("gap_hit_stall", {31'h0, Stall_2IF}, 32'd0);
    chk("gap_hit_instr0", Instr1_2IF, 32'h3000);
    step();
    Instr_address_fIF = 32'hBFC0_001C;
    #1;
    chk("gap_hit_instr3", Instr1_2IF, 32'h3003);

    // Flush during beat 1 of a fill.
    step();
    Instr_address_fIF = 32'hBFC0_0020;
    #1;
    chk("fl_stall0", {31'h0, Stall_2IF}, 32'd1);
    step();
    Mem_valid = 1'b1;
    Mem_data  = 32'h4000;
    #1;
    chk("fl_addr0", Mem_addr, 32'hBFC0_0020);
    step();
    Mem_data = 32'h4001;
    Flush    = 1'b1;
    #1;
    chk("fl_addr1", Mem_addr, 32'hBFC0_0024);
    step();
    Flush    = 1'b0;
    Mem_data = 32'h4002;
    step();
    Mem_data = 32'h4003;
    #1;
    chk("fl_addr3", Mem_addr, 32'hBFC0_002C);
    step();
    Mem_valid = 1'b0;
    #1;
    chk("fl_done_req", {31'h0, Mem_req}, 32'd0);
    chk("fl_done_stall", {31'h0, Stall_2IF}, 32'd1);
    step();
    #1;
    chk("fl_same_miss", {31'h0, Stall_2IF}, 32'd1);
    chk("fl_same_instr", Instr1_2IF, 32'h0);
    Instr_address_fIF = 32'hBFC0_0000;
    #1;
    chk("fl_line0_miss", {31'h0, Stall_2IF}, 32'd1);
    Instr_address_fIF = 32'hBFC0_0010;
    #1;
    chk("fl_line1_miss", {31'h0, Stall_2IF}, 32'd1);
    Instr_address_fIF = 32'hBFC0_0020;

    // Reset during beat 2 of the refill.
    step();
    Mem_valid = 1'b1;
    Mem_data  = 32'h5000;
    #1;
    chk("rf_req", {31'h0, Mem_req}, 32'd1);
    chk("miss_cnt_before_rst", Miss_count, pexp(6));
    step();
    Mem_data = 32'h5001;
    step();
    Mem_data = 32'h5002;
    #1;
    chk("rf_addr2", Mem_addr, 32'hBFC0_0028);
    RESET = 1'b0;
    #1;
    chk("rf_req_low", {31'h0, Mem_req}, 32'd0);
    chk("rf_addr_low", Mem_addr, 32'h0);
    chk("rf_stall_low", {31'h0, Stall_2IF}, 32'd0);
    chk("rf_instr_low", Instr1_2IF, 32'h0);
    chk("rf_hit_cnt", Hit_count, 32'h0);
    chk("rf_miss_cnt", Miss_count, 32'h0);
    @(negedge CLK);
    RESET     = 1'b1;
    Mem_valid = 1'b0;
    #1;
    chk("rf_remiss_stall", {31'h0, Stall_2IF}, 32'd1);
    chk("rf_remiss_instr", Instr1_2IF, 32'h0);
    do_fill(32'hBFC0_0020, 32'h6000, 1'b0);
    step();
    #1;
    chk("rf_hit_instr", Instr1_2IF, 32'h6000);
    chk("rf_miss_cnt_after", Miss_count, pexp(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
